// File: rtl/mem_stage_lsu_if.sv
// Data-memory bus between the LSU (master) and data memory (slave):
// registered request side, single-cycle ack with read data.
interface mem_stage_lsu_if #(
  parameter int ADDR_W = 32
);
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// Registered load/store unit between EX/MEM and MEM/WB. Issues byte/half/word
// accesses on a req/ack bus, stalls upstream while busy, and reports
// misaligned, illegal-size and bus-timeout exceptions.
module mem_stage_lsu #(
  parameter int ADDR_W      = 32,
  parameter int RD_W        = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic              in_memread,
  input  logic              in_memwrite,
  input  logic [2:0]        in_funct3,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [31:0]       in_wdata,
  input  logic [RD_W-1:0]   in_rd,
  input  logic              in_regwrite,
  input  logic [1:0]        in_resultsrc,
  input  logic [ADDR_W-1:0] in_pcplus4,
  output logic              stall_o,
  mem_stage_lsu_if.master   bus,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_aluresult,
  output logic [31:0]       out_readdata,
  output logic [RD_W-1:0]   out_rd,
  output logic              out_regwrite,
  output logic [1:0]        out_resultsrc,
  output logic [ADDR_W-1:0] out_pcplus4,
  output logic              exc_o,
  output logic [1:0]        exc_cause
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt;
  logic               memop, sz_ok, align_ok;
  logic [1:0]         cause;
  logic [3:0]         be_d;
  logic [31:0]        wdata_d;
  logic               accept, ack_done, tmo, stall;
  logic               tmo_hit;
  logic [31:0]        lane, ld_data;

  logic               cap_load;
  logic [2:0]         cap_f3;
  logic [1:0]         cap_off;
  logic [ADDR_W-1:0]  cap_addr;
  logic [RD_W-1:0]    cap_rd;
  logic               cap_regwrite;
  logic [1:0]         cap_resultsrc;
  logic [ADDR_W-1:0]  cap_pc;

  // Decode the incoming entry: legality, alignment, byte enables, store lanes.
  always_comb begin
    memop = in_valid & (in_memread | in_memwrite);
    sz_ok = 1'b0;
    if (in_memread && !in_memwrite)
      sz_ok = in_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else if (in_memwrite && !in_memread)
      sz_ok = in_funct3 inside {3'b000, 3'b001, 3'b010};
    case (in_funct3[1:0])
      2'b01:   align_ok = ~in_addr[0];
      2'b10:   align_ok = (in_addr[1:0] == 2'b00);
      default: align_ok = 1'b1;
    endcase
    if (!memop)        cause = 2'b00;
    else if (!sz_ok)   cause = 2'b10;
    else if (!align_ok) cause = 2'b01;
    else               cause = 2'b00;
    case (in_funct3[1:0])
      2'b00: begin
        be_d    = 4'b0001 << in_addr[1:0];
        wdata_d = {4{in_wdata[7:0]}};
      end
      2'b01: begin
        be_d    = 4'b0011 << in_addr[1:0];
        wdata_d = {2{in_wdata[15:0]}};
      end
      default: begin
        be_d    = 4'b1111;
        wdata_d = in_wdata;
      end
    endcase
  end

  // Select the addressed lane of the returned word and extend it.
  always_comb begin
    lane = bus.mem_rdata >> {cap_off, 3'b000};
    case (cap_f3)
      3'b000:  ld_data = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_data = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_data = {24'b0, lane[7:0]};
      3'b101:  ld_data = {16'b0, lane[15:0]};
      default: ld_data = bus.mem_rdata;
    endcase
  end

  assign tmo_hit = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Next-state and handshake decisions; stall is forced low while in reset.
  always_comb begin
    state_d  = state;
    accept   = 1'b0;
    ack_done = 1'b0;
    tmo      = 1'b0;
    stall    = 1'b0;
    case (state)
      S_IDLE: begin
        if (memop && cause == 2'b00) begin
          accept  = 1'b1;
          stall   = 1'b1;
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (bus.mem_ack) begin
          ack_done = 1'b1;
          state_d  = S_IDLE;
        end else if (tmo_hit) begin
          tmo     = 1'b1;
          state_d = S_IDLE;
        end else begin
          stall = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
    stall_o = stall & rst_n;
  end

  // State register and wait-cycle counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_d;
      if (state == S_BUSY && !ack_done && !tmo) cnt <= cnt + 1'b1;
      else                                      cnt <= '0;
    end
  end

  // Bus request registers and captured sideband of the outstanding access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
      cap_load      <= 1'b0;
      cap_f3        <= '0;
      cap_off       <= '0;
      cap_addr      <= '0;
      cap_rd        <= '0;
      cap_regwrite  <= 1'b0;
      cap_resultsrc <= '0;
      cap_pc        <= '0;
    end else if (accept) begin
      bus.mem_req   <= 1'b1;
      bus.mem_we    <= in_memwrite;
      bus.mem_addr  <= {in_addr[ADDR_W-1:2], 2'b00};
      bus.mem_be    <= be_d;
      bus.mem_wdata <= wdata_d;
      cap_load      <= in_memread;
      cap_f3        <= in_funct3;
      cap_off       <= in_addr[1:0];
      cap_addr      <= in_addr;
      cap_rd        <= in_rd;
      cap_regwrite  <= in_regwrite;
      cap_resultsrc <= in_resultsrc;
      cap_pc        <= in_pcplus4;
    end else if (ack_done || tmo) begin
      bus.mem_req <= 1'b0;
      bus.mem_we  <= 1'b0;
    end
  end

  // MEM/WB register: direct entries retire from IDLE, bus accesses on ack/timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_aluresult <= '0;
      out_readdata  <= '0;
      out_rd        <= '0;
      out_regwrite  <= 1'b0;
      out_resultsrc <= '0;
      out_pcplus4   <= '0;
      exc_o         <= 1'b0;
      exc_cause     <= '0;
    end else begin
      out_valid    <= 1'b0;
      out_regwrite <= 1'b0;
      out_readdata <= '0;
      exc_o        <= 1'b0;
      exc_cause    <= '0;
      if (state == S_IDLE && in_valid && !accept) begin
        out_valid     <= 1'b1;
        out_aluresult <= in_addr;
        out_rd        <= in_rd;
        out_resultsrc <= in_resultsrc;
        out_pcplus4   <= in_pcplus4;
        out_regwrite  <= in_regwrite & (cause == 2'b00);
        exc_o         <= (cause != 2'b00);
        exc_cause     <= cause;
      end else if (ack_done || tmo) begin
        out_valid     <= 1'b1;
        out_aluresult <= cap_addr;
        out_rd        <= cap_rd;
        out_resultsrc <= cap_resultsrc;
        out_pcplus4   <= cap_pc;
        out_regwrite  <= cap_regwrite & ack_done;
        out_readdata  <= (ack_done && cap_load) ? ld_data : '0;
        exc_o         <= tmo;
        exc_cause     <= tmo ? 2'b11 : 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized self-checking bench for mem_stage_lsu with a transaction-level
// reference model and a bench-driven memory responder.
module tb_mem_stage_lsu;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_memread, in_memwrite, in_regwrite;
  logic [2:0]  in_funct3;
  logic [31:0] in_addr, in_wdata, in_pcplus4;
  logic [4:0]  in_rd;
  logic [1:0]  in_resultsrc;
  logic        stall_o, out_valid, out_regwrite, exc_o;
  logic [31:0] out_aluresult, out_readdata, out_pcplus4;
  logic [4:0]  out_rd;
  logic [1:0]  out_resultsrc, exc_cause;

  int n_checks = 0;
  int n_errors = 0;

  mem_stage_lsu_if #(.ADDR_W(32)) bus ();

  mem_stage_lsu #(.ADDR_W(32), .RD_W(5), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_memread(in_memread), .in_memwrite(in_memwrite),
    .in_funct3(in_funct3), .in_addr(in_addr), .in_wdata(in_wdata),
    .in_rd(in_rd), .in_regwrite(in_regwrite), .in_resultsrc(in_resultsrc),
    .in_pcplus4(in_pcplus4), .stall_o(stall_o), .bus(bus),
    .out_valid(out_valid), .out_aluresult(out_aluresult),
    .out_readdata(out_readdata), .out_rd(out_rd), .out_regwrite(out_regwrite),
    .out_resultsrc(out_resultsrc), .out_pcplus4(out_pcplus4),
    .exc_o(exc_o), .exc_cause(exc_cause)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] rdata);
    int unsigned off = addr % 4;
    int b = int'((rdata >> (8 * off)) & 32'hFF);
    int h = int'((rdata >> (8 * off)) & 32'hFFFF);
    case (f3)
      3'd0: return (b >= 128) ? 32'(b - 256) : 32'(b);
      3'd1: return (h >= 32768) ? 32'(h - 65536) : 32'(h);
      3'd4: return 32'(b);
      3'd5: return 32'(h);
      default: return rdata;
    endcase
  endfunction

  // One EX/MEM entry from presentation to MEM/WB result. Starts and ends just
  // after a falling edge. waits >= TMO-1 means memory never answers.
  task automatic run_txn(input bit v, input bit rd_, input bit wr_, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rdata, input int waits);
    logic [4:0]  rdi  = 5'($urandom);
    logic        rw   = 1'($urandom);
    logic [1:0]  rs   = 2'($urandom);
    logic [31:0] pc   = $urandom;
    bit          memop = v && (rd_ || wr_);
    bit          legal;
    int unsigned nbytes = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
    logic [1:0]  cause;
    logic [3:0]  be;
    logic [31:0] wd;
    bit          go;

    if (rd_ && wr_)  legal = 0;
    else if (rd_)    legal = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
    else             legal = (f3 <= 2);
    cause = !memop ? 2'd0 : !legal ? 2'd2 : (addr % nbytes != 0) ? 2'd1 : 2'd0;
    go = memop && cause == 0;
    be = (nbytes == 4) ? 4'hF : 4'((nbytes == 2 ? 3 : 1) << (addr % 4));
    wd = (nbytes == 1) ? (wdata & 32'hFF) * 32'h01010101 :
         (nbytes == 2) ? (wdata & 32'hFFFF) * 32'h00010001 : wdata;

    in_valid = v; in_memread = rd_; in_memwrite = wr_; in_funct3 = f3;
    in_addr = addr; in_wdata = wdata; in_rd = rdi; in_regwrite = rw;
    in_resultsrc = rs; in_pcplus4 = pc;
    #1 check("stall_accept", stall_o, go);
    @(posedge clk); @(negedge clk);

    if (!go) begin
      check("direct_valid", out_valid, v);
      check("direct_regwrite", out_regwrite, v && rw && cause == 0);
      check("direct_req", bus.mem_req, 0);
      if (v) begin
        check("direct_exc", exc_o, cause != 0);
        check("direct_cause", exc_cause, cause);
        check("direct_rdata", out_readdata, 0);
        check("direct_rd", out_rd, rdi);
        check("direct_alu", out_aluresult, addr);
        check("direct_pc", out_pcplus4, pc);
      end
      return;
    end

    check("req", bus.mem_req, 1);
    check("we", bus.mem_we, wr_);
    check("addr", bus.mem_addr, addr & ~32'h3);
    check("be", bus.mem_be, be);
    if (wr_) check("wdata", bus.mem_wdata, wd);

    if (waits >= TMO - 1) begin
      for (int i = 0; i < TMO - 1; i++) begin
        check("tmo_stall", stall_o, 1);
        @(posedge clk); @(negedge clk);
        check("tmo_req_held", bus.mem_req, 1);
        check("tmo_no_valid", out_valid, 0);
      end
      check("tmo_stall_release", stall_o, 0);
      @(posedge clk); @(negedge clk);
      check("tmo_valid", out_valid, 1);
      check("tmo_exc", exc_o, 1);
      check("tmo_cause", exc_cause, 3);
      check("tmo_regwrite", out_regwrite, 0);
      check("tmo_req_drop", bus.mem_req, 0);
      check("tmo_rd", out_rd, rdi);
      return;
    end

    for (int i = 0; i < waits; i++) begin
      check("wait_stall", stall_o, 1);
      @(posedge clk); @(negedge clk);
      check("wait_req_held", bus.mem_req, 1);
      check("wait_be_held", bus.mem_be, be);
      check("wait_no_valid", out_valid, 0);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = rdata;
    #1 check("ack_stall", stall_o, 0);
    @(posedge clk); @(negedge clk);
    bus.mem_ack = 1'b0; bus.mem_rdata = $urandom;
    check("ack_valid", out_valid, 1);
    check("ack_exc", exc_o, 0);
    check("ack_cause", exc_cause, 0);
    check("ack_req_drop", bus.mem_req, 0);
    check("ack_rdata", out_readdata, rd_ ? model_load(f3, addr, rdata) : 32'h0);
    check("ack_regwrite", out_regwrite, rw);
    check("ack_rd", out_rd, rdi);
    check("ack_alu", out_aluresult, addr);
    check("ack_pc", out_pcplus4, pc);
    check("ack_rsrc", out_resultsrc, rs);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 0; in_memread = 0; in_memwrite = 0; in_funct3 = 0; in_addr = 0;
    in_wdata = 0; in_rd = 0; in_regwrite = 0; in_resultsrc = 0; in_pcplus4 = 0;
    bus.mem_ack = 1'b0; bus.mem_rdata = '0;
    repeat (2) @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_req", bus.mem_req, 0);
    check("rst_stall", stall_o, 0);
    check("rst_exc", exc_o, 0);
    check("rst_rdata", out_readdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed scenarios.
    run_txn(1, 1, 0, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 3);
    run_txn(1, 1, 0, 3'd0, 32'h103, 32'h0, 32'h80123456, 1);
    run_txn(1, 1, 0, 3'd4, 32'h103, 32'h0, 32'h80123456, 0);
    run_txn(1, 0, 1, 3'd1, 32'h202, 32'h0000A5C3, 32'h0, 2);
    run_txn(1, 1, 0, 3'd2, 32'h101, 32'h0, 32'h0, 0);
    run_txn(1, 1, 0, 3'd3, 32'h100, 32'h0, 32'h0, 0);
    run_txn(1, 1, 1, 3'd2, 32'h100, 32'h0, 32'h0, 0);
    run_txn(0, 1, 0, 3'd2, 32'h100, 32'h0, 32'h0, 0);
    run_txn(1, 1, 0, 3'd2, 32'h300, 32'h0, 32'h0, TMO);
    run_txn(1, 1, 0, 3'd2, 32'h304, 32'h0, 32'h12345678, 1);

    // Random entries.
    for (int n = 0; n < 200; n++) begin
      int unsigned kind = $urandom_range(0, 9);
      bit v = ($urandom_range(0, 9) != 0);
      bit rd_ = (kind < 5) || (kind == 9);
      bit wr_ = (kind >= 5 && kind < 8) || (kind == 9);
      logic [2:0] f3 = 3'($urandom);
      logic [31:0] addr = $urandom & 32'hFFFF;
      if ($urandom_range(0, 1) == 1) addr = addr & ~32'((f3 % 4 == 0) ? 0 : (f3 % 4 == 1) ? 1 : 3);
      run_txn(v, rd_, wr_, f3, addr, $urandom, $urandom, int'($urandom_range(0, 4)));
    end

    // Reset in the middle of an outstanding access, then a stray ack.
    in_valid = 1; in_memread = 1; in_memwrite = 0; in_funct3 = 3'd2; in_addr = 32'h400;
    @(posedge clk); @(negedge clk);
    check("pre_rst_req", bus.mem_req, 1);
    @(posedge clk); @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req", bus.mem_req, 0);
    check("midrst_stall", stall_o, 0);
    check("midrst_valid", out_valid, 0);
    in_valid = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'hCAFEF00D;
    @(posedge clk); @(negedge clk);
    bus.mem_ack = 1'b0;
    check("late_ack_valid", out_valid, 0);
    check("late_ack_req", bus.mem_req, 0);
    @(posedge clk); @(negedge clk);
    check("late_ack_valid2", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage_lsu.md
Name: mem_stage_lsu

Overview:
- Parametrised successor to the pipeline memory stage: a registered load/store unit between EX/MEM and MEM/WB.
- Handles byte/half/word loads and stores with byte enables and sign/zero extension.
- Talks to data memory over a req/ack bus with arbitrary wait states and a timeout.
- Stalls the upstream pipeline while an access is outstanding; flags misaligned and illegal-size accesses.

Parameters:
ADDR_W, 32, address width of in_addr, out_aluresult and mem_addr
RD_W, 5, destination register index width
TIMEOUT_CYC, 64, cycles in BUSY without mem_ack before a bus timeout is raised (>=2)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  EX/MEM entry valid
in_memread  input  1  load
in_memwrite  input  1  store
in_funct3  input  3  access size/sign (RV32I encoding)
in_addr  input  ADDR_W  effective address (ALU result)
in_wdata  input  32  store data
in_rd  input  RD_W  destination register
in_regwrite  input  1  writeback enable
in_resultsrc  input  2  writeback mux select
in_pcplus4  input  ADDR_W  PC+4
stall_o  output  1  hold EX/MEM stable and freeze upstream
mem_req  output  1  bus request
mem_we  output  1  bus write
mem_addr  output  ADDR_W  word-aligned address {in_addr[ADDR_W-1:2],2'b00}
mem_be  output  4  byte enables
mem_wdata  output  32  lane-replicated store data
mem_ack  input  1  bus completion; valid for one cycle
mem_rdata  input  32  read data, valid with mem_ack
out_valid  output  1  MEM/WB entry valid
out_aluresult  output  ADDR_W  registered in_addr
out_readdata  output  32  extended load data (0 for non-loads)
out_rd  output  RD_W  registered in_rd
out_regwrite  output  1  registered in_regwrite, gated by exception
out_resultsrc  output  2  registered in_resultsrc
out_pcplus4  output  ADDR_W  registered in_pcplus4
exc_o  output  1  exception pulse, aligned with out_valid
exc_cause  output  2  01 misaligned, 10 illegal size, 11 bus timeout; 00 when exc_o=0

Behaviour:
- Reset: state IDLE; every output 0; timeout counter 0. Reset mid-access aborts it and drops mem_req immediately; no out_valid is produced for the aborted access.
- Mem op = in_valid & (in_memread | in_memwrite). memread and memwrite both set: treated as illegal size.
- Size legality: loads accept funct3 000/001/010/100/101; stores accept 000/001/010. Anything else gives cause 10.
- Alignment: half requires addr[0]=0; word requires addr[1:0]=00. A violation gives cause 01.
- Any exception: no bus access. Result registered in 1 cycle with out_valid=1, exc_o=1, out_regwrite=0, out_readdata=0.
- Non-mem entry (in_valid=1): registered in 1 cycle; out_valid=1, out_readdata=0, no stall.
- Bubble (in_valid=0): next cycle out_valid=0 and out_regwrite=0.
- FSM IDLE: on a legal mem op, capture address, be, wdata and sideband; assert mem_req, mem_we, mem_addr, mem_be and mem_wdata registered; go to BUSY. stall_o=1 combinationally in this cycle.
- FSM BUSY:
  - Bus outputs stay stable until mem_ack; stall_o = ~mem_ack.
  - On mem_ack: drop mem_req and register the result. out_valid=1 next cycle. Return to IDLE. Upstream advances on the same edge, and the entry is not re-accepted.
  - mem_ack in IDLE is ignored.
- Timeout: the counter increments each BUSY cycle without ack. At TIMEOUT_CYC the access completes: exc_cause=11, out_regwrite=0, mem_req dropped, stall_o=0 that cycle.
- Byte enables, with off=addr[1:0]:
  - byte: 4'b0001<<off
  - half: 4'b0011<<off
  - word: 4'b1111
- Store data: SB replicates wdata[7:0] to all lanes; SH replicates [15:0] to both halves.
- Load data: select the lane by off, then extend:
  - LB/LH sign-extend.
  - LBU/LHU zero-extend.
  - LW passes through.
- Stores: out_readdata=0; out_regwrite passes as given (normally 0).

Test Plan:
- LW addr 0x100, mem_ack after 3 wait cycles, rdata 0xDEADBEEF -> stall_o high 4 cycles, mem_be=1111; one out_valid with readdata 0xDEADBEEF, rd preserved.
- LB addr 0x103, rdata 0x80123456 -> be=1000, readdata 0xFFFFFF80; LBU same access -> 0x00000080.
- SH addr 0x202, wdata 0x0000A5C3 -> mem_we=1, be=1100, mem_wdata 0xA5C3A5C3, mem_addr 0x200.
- LW addr 0x101 -> no mem_req, exc_o=1, cause 01, out_regwrite=0; funct3=011 load -> cause 10.
- No mem_ack for TIMEOUT_CYC=64 cycles -> mem_req drops, exc_o=1 cause 11, stall_o released; later a LW completes normally.
- rst_n low while BUSY -> mem_req, stall_o and out_valid 0 asynchronously; a late mem_ack after reset is ignored.
